reg_writeback: RTL and testbench
================================

# reg_writeback

Writeback collector between the execution units and the general-purpose register file's single write port. It accepts results from the ALU (one per cycle) and the load/store unit (variable latency) over valid/ready handshakes and buffers them in a small in-order queue. It drains one entry per cycle onto the register file's `rd`/`dat`/`w_en` port. It also reports read-after-write hazards for the decode stage's source registers against every still-pending write.

## Interface
- `ADDR_WIDTH`, default 5: register index width.
- `DATA_WIDTH`, default 32: register data width.
- `FIFO_DEPTH`, default 4: queue entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `alu_valid_i` in 1: ALU result valid.
- `alu_ready_o` out 1: ALU result accepted this cycle if valid.
- `alu_rd_i` in ADDR_WIDTH: ALU destination register.
- `alu_dat_i` in DATA_WIDTH: ALU result.
- `lsu_valid_i` in 1: load result valid.
- `lsu_ready_o` out 1: load result accepted.
- `lsu_rd_i` in ADDR_WIDTH: load destination register.
- `lsu_dat_i` in DATA_WIDTH: load data.
- `rd_o` out ADDR_WIDTH: register file write index.
- `dat_o` out DATA_WIDTH: register file write data.
- `w_en_o` out 1: register file write enable.
- `chk_rs1_i` in ADDR_WIDTH: decode source 1 to check.
- `chk_rs2_i` in ADDR_WIDTH: decode source 2 to check.
- `hazard_o` out 1: a pending write targets `chk_rs1_i` or `chk_rs2_i`.

## Operation
- Queue holds {rd, dat} entries in order. `count` ranges 0..FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.
- Transfer occurs when valid && ready are both high in the same cycle. Producers must hold payload stable while valid && !ready.
- Entries with rd = 0 are handshaken normally (ready follows the rules below) but are never stored.
- Drain:
  - `w_en_o` = (count != 0); `rd_o`/`dat_o` = head entry.
  - The register file always accepts, so the head pops every cycle `w_en_o` is high.
  - When empty, `rd_o` = 0, `dat_o` = 0.
- Space available this cycle: `space = FIFO_DEPTH − count + (count != 0)`; a pop in the same cycle frees a slot.
- Ready rules:
  - `lsu_ready_o` = (space ≥ 1), or `lsu_rd_i` = 0.
  - `alu_ready_o` = (space ≥ 1 + lsu_push), or `alu_rd_i` = 0, where lsu_push = `lsu_valid_i` && `lsu_rd_i` != 0 && space ≥ 1.
- Same-cycle pushes: the LSU has priority. When both sources push, the LSU entry is stored first, then the ALU entry.
- `hazard_o` = OR over occupied entries (head included) of (entry.rd == chk_rs1_i && chk_rs1_i != 0) or (entry.rd == chk_rs2_i && chk_rs2_i != 0). Entries pushed in the current cycle are not included.
- Width rules:
  - `count` is log2(FIFO_DEPTH)+1 bits.
  - Per-cycle update: count_next = count + pushes (0..2) − pop (0/1).

## Timing
- Reset (`rst` high at an edge): count = 0, pointers = 0, all entries discarded, including mid-operation contents.
- While `rst` is high, `alu_ready_o` = `lsu_ready_o` = 0, `w_en_o` = 0, `hazard_o` = 0.
- From the first cycle after `rst` deasserts, both readies are 1.
- Latency: a result accepted at edge N appears on `w_en_o`/`rd_o`/`dat_o` in the cycle after edge N, if the queue was empty. The register file commits it at edge N+1.
- Throughput: 1 write per cycle; up to 2 pushes per cycle.
- Full boundary (count = FIFO_DEPTH): space = FIFO_DEPTH − FIFO_DEPTH + 1 = 1, so exactly one push per cycle is possible (LSU first).
- `hazard_o`, the readies, and the write outputs are combinational from state and inputs; no registered outputs.

## Structure
- Shared package:
  - ADDR_WIDTH and DATA_WIDTH constants, common with the register file.
  - `wb_entry_t` struct {rd, dat}.
- Sub-module `wb_fifo`:
  - Dual-push, single-pop queue of `wb_entry_t`.
  - Exposes count and a per-entry occupied/rd vector for the hazard compare.
- Top level holds the ready logic, rd = 0 filtering, and hazard compare.

## Test plan
- Reset then a single ALU push (rd = 5, dat = 0x1234) → in the next cycle `w_en_o` = 1, `rd_o` = 5, `dat_o` = 0x1234. The cycle after that, `w_en_o` = 0.
- Same-cycle ALU (rd = 3, 0xA) and LSU (rd = 7, 0xB) pushes into an empty queue → the LSU write (7, 0xB) precedes the ALU write (3, 0xA) on consecutive cycles.
- Fill with 4 LSU entries while both sources are held valid → at count = 4 exactly one push per cycle (LSU). `alu_ready_o` = 0 until space ≥ 2. No entry is lost or duplicated.
- ALU push with rd = 0, dat = 0xFFFF → `alu_ready_o` = 1, `w_en_o` never asserts, count stays 0.
- Pending entry rd = 9 with `chk_rs1_i` = 9 → `hazard_o` = 1 until the write cycle completes.
  - `chk_rs1_i` = 0 against a pending rd = 0 request → `hazard_o` = 0.
- Assert `rst` with 3 entries queued → the next cycle has `w_en_o` = 0, `hazard_o` = 0, and readies 0. After deassert, the queue is empty.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared types and widths for the writeback collector and the register file.
// The default widths here match the register file's write port.
package reg_writeback_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0] dat;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order queue with two pushes per cycle (port 0 stored first) and one pop.
// Every slot is exposed with an occupied flag so the caller can search pending writes.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter type entry_t    = wb_entry_t,
  parameter int  FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push0_i,
  input  entry_t                ent0_i,
  input  logic                  push1_i,
  input  entry_t                ent1_i,
  input  logic                  pop_i,
  output entry_t                head_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [FIFO_DEPTH-1:0] occ_o,
  output entry_t                ent_o [FIFO_DEPTH]
);

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr1_idx;

  // Port 1 lands directly behind port 0 when both push together.
  always_comb begin
    wr1_idx  = wr_ptr_q + PTR_W'(push0_i);
    wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wr_ptr_q] <= ent0_i;
    if (push1_i) mem_q[wr1_idx]  <= ent1_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] offset;
    // Slot distance from the head, modulo the depth; occupied when inside count.
    assign offset    = PTR_W'(gi) - rd_ptr_q;
    assign occ_o[gi] = ({1'b0, offset} < count_q);
    assign ent_o[gi] = mem_q[gi];
  end

endmodule

// File: rtl/reg_writeback.sv
// Writeback collector: merges ALU and LSU results into one register-file write
// port and flags read-after-write hazards against every still-pending write.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [ADDR_WIDTH-1:0] alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_dat_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_dat_i,
  output logic [ADDR_WIDTH-1:0] rd_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  w_en_o,
  input  logic [ADDR_WIDTH-1:0] chk_rs1_i,
  input  logic [ADDR_WIDTH-1:0] chk_rs2_i,
  output logic                  hazard_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] dat;
  } entry_t;

  entry_t               head, lsu_ent, alu_ent;
  entry_t               ent [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] occ, hit;
  logic [CNT_W-1:0]     count, space;
  logic                 not_empty, lsu_room, alu_room, lsu_push, alu_push;

  // The same-cycle pop frees a slot, so a full queue still takes one push.
  always_comb begin
    not_empty = (count != '0);
    space     = CNT_W'(FIFO_DEPTH) - count + CNT_W'(not_empty);
    lsu_room  = (space >= CNT_W'(1));
    lsu_push  = !rst && lsu_valid_i && (lsu_rd_i != '0) && lsu_room;
    alu_room  = (space >= (lsu_push ? CNT_W'(2) : CNT_W'(1)));
    alu_push  = !rst && alu_valid_i && (alu_rd_i != '0) && alu_room;
  end

  // Writes to x0 are acknowledged but dropped before the queue.
  assign lsu_ready_o = !rst && (lsu_room || (lsu_rd_i == '0));
  assign alu_ready_o = !rst && (alu_room || (alu_rd_i == '0));

  assign lsu_ent = '{rd: lsu_rd_i, dat: lsu_dat_i};
  assign alu_ent = '{rd: alu_rd_i, dat: alu_dat_i};

  wb_fifo #(
    .entry_t   (entry_t),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push0_i(lsu_push),
    .ent0_i (lsu_ent),
    .push1_i(alu_push),
    .ent1_i (alu_ent),
    .pop_i  (w_en_o),
    .head_o (head),
    .count_o(count),
    .occ_o  (occ),
    .ent_o  (ent)
  );

  assign w_en_o = !rst && not_empty;
  assign rd_o   = w_en_o ? head.rd  : '0;
  assign dat_o  = w_en_o ? head.dat : '0;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_hazard
    assign hit[gi] = occ[gi] &&
                     (((ent[gi].rd == chk_rs1_i) && (chk_rs1_i != '0)) ||
                      ((ent[gi].rd == chk_rs2_i) && (chk_rs2_i != '0)));
  end

  assign hazard_o = !rst && (|hit);

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: latency, LSU priority, full-queue backpressure,
// x0 filtering, hazard reporting and mid-operation reset.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i, lsu_valid_i;
  logic        alu_ready_o, lsu_ready_o;
  logic [4:0]  alu_rd_i, lsu_rd_i, rd_o, chk_rs1_i, chk_rs2_i;
  logic [31:0] alu_dat_i, lsu_dat_i, dat_o;
  logic        w_en_o, hazard_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid_i(alu_valid_i),
    .alu_ready_o(alu_ready_o),
    .alu_rd_i   (alu_rd_i),
    .alu_dat_i  (alu_dat_i),
    .lsu_valid_i(lsu_valid_i),
    .lsu_ready_o(lsu_ready_o),
    .lsu_rd_i   (lsu_rd_i),
    .lsu_dat_i  (lsu_dat_i),
    .rd_o       (rd_o),
    .dat_o      (dat_o),
    .w_en_o     (w_en_o),
    .chk_rs1_i  (chk_rs1_i),
    .chk_rs2_i  (chk_rs2_i),
    .hazard_o   (hazard_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic we, input logic [4:0] rd,
                           input logic [31:0] dat);
    check({tag, ".w_en"}, 32'(w_en_o), 32'(we));
    check({tag, ".rd"},   32'(rd_o),   32'(rd));
    check({tag, ".dat"},  dat_o,       dat);
  endtask

  // Fill scenario: expected drain order and ALU backpressure, cycle by cycle.
  logic [4:0]  exp_rd  [10] = '{5'd0, 5'd16, 5'd24, 5'd17, 5'd25, 5'd18, 5'd26, 5'd19, 5'd27, 5'd0};
  logic [31:0] exp_dat [10] = '{32'h0, 32'h100, 32'h200, 32'h101, 32'h201,
                                32'h102, 32'h202, 32'h103, 32'h203, 32'h0};
  logic        exp_we  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        exp_ardy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int  li, ai;
    logic la, aa;
    rst = 1'b1;
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_dat_i = '0;
    lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_dat_i = '0;
    chk_rs1_i = '0; chk_rs2_i = '0;

    // Reset state
    repeat (2) cyc();
    check("rst.alu_ready", 32'(alu_ready_o), 0);
    check("rst.lsu_ready", 32'(lsu_ready_o), 0);
    check("rst.w_en",      32'(w_en_o), 0);
    check("rst.hazard",    32'(hazard_o), 0);
    rst = 1'b0;
    #1;
    check("post_rst.alu_ready", 32'(alu_ready_o), 1);
    check("post_rst.lsu_ready", 32'(lsu_ready_o), 1);
    $display("vec reset: done");

    // Single ALU push: visible the next cycle, gone the cycle after
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_dat_i = 32'h1234;
    #1;
    check("single.alu_ready", 32'(alu_ready_o), 1);
    cyc();
    alu_valid_i = 1'b0;
    #1;
    check_out("single.c1", 1'b1, 5'd5, 32'h1234);
    cyc();
    check_out("single.c2", 1'b0, 5'd0, 32'h0);
    $display("vec single ALU push rd=5: done");

    // Simultaneous pushes: LSU drains first
    alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_dat_i = 32'hA;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_dat_i = 32'hB;
    #1;
    check("dual.alu_ready", 32'(alu_ready_o), 1);
    check("dual.lsu_ready", 32'(lsu_ready_o), 1);
    cyc();
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    #1;
    check_out("dual.c1", 1'b1, 5'd7, 32'hB);
    cyc();
    check_out("dual.c2", 1'b1, 5'd3, 32'hA);
    cyc();
    check_out("dual.c3", 1'b0, 5'd0, 32'h0);
    $display("vec dual push LSU rd=7 / ALU rd=3: done");

    // Fill: both producers held valid, four entries each
    li = 0; ai = 0;
    for (int c = 0; c < 10; c++) begin
      lsu_valid_i = (li < 4); lsu_rd_i = 5'(16 + li); lsu_dat_i = 32'(32'h100 + li);
      alu_valid_i = (ai < 4); alu_rd_i = 5'(24 + ai); alu_dat_i = 32'(32'h200 + ai);
      #1;
      check_out($sformatf("fill.c%0d", c), exp_we[c], exp_rd[c], exp_dat[c]);
      if (c < 5) begin
        check($sformatf("fill.c%0d.alu_ready", c), 32'(alu_ready_o), 32'(exp_ardy[c]));
        check($sformatf("fill.c%0d.lsu_ready", c), 32'(lsu_ready_o), 1);
      end
      la = lsu_valid_i && lsu_ready_o;
      aa = alu_valid_i && alu_ready_o;
      $display("vec fill cycle %0d: lsu_acc=%0b alu_acc=%0b w_en=%0b rd=%0d", c, la, aa, w_en_o, rd_o);
      cyc();
      if (la) li++;
      if (aa) ai++;
    end
    lsu_valid_i = 1'b0; alu_valid_i = 1'b0;

    // Writes to x0 are accepted and dropped
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_dat_i = 32'hFFFF;
    #1;
    check("x0.alu_ready", 32'(alu_ready_o), 1);
    cyc();
    alu_valid_i = 1'b0;
    #1;
    check("x0.w_en.c1", 32'(w_en_o), 0);
    cyc();
    check("x0.w_en.c2", 32'(w_en_o), 0);
    $display("vec ALU push rd=0: done");

    // Hazard on rs1 until the write retires
    alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_dat_i = 32'h99; chk_rs1_i = 5'd9;
    #1;
    check("haz.same_cycle", 32'(hazard_o), 0);
    cyc();
    alu_valid_i = 1'b0;
    #1;
    check("haz.pending", 32'(hazard_o), 1);
    check_out("haz.write", 1'b1, 5'd9, 32'h99);
    cyc();
    check("haz.retired", 32'(hazard_o), 0);
    // Hazard on rs2 only, then removed by clearing rs2
    alu_valid_i = 1'b1; chk_rs1_i = 5'd8; chk_rs2_i = 5'd9;
    cyc();
    alu_valid_i = 1'b0;
    #1;
    check("haz.rs2", 32'(hazard_o), 1);
    chk_rs2_i = 5'd0;
    #1;
    check("haz.nomatch", 32'(hazard_o), 0);
    cyc();
    // x0 source against an x0 request
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; chk_rs1_i = 5'd0;
    cyc();
    alu_valid_i = 1'b0;
    #1;
    check("haz.x0", 32'(hazard_o), 0);
    $display("vec hazard rd=9 rs1/rs2 and x0: done");

    // Reset with three entries queued
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_dat_i = 32'hA0;
    alu_valid_i = 1'b1; alu_rd_i = 5'd11; alu_dat_i = 32'hB0;
    cyc();
    lsu_rd_i = 5'd12; lsu_dat_i = 32'hC0;
    alu_rd_i = 5'd13; alu_dat_i = 32'hD0;
    cyc();
    lsu_valid_i = 1'b0; alu_valid_i = 1'b0; chk_rs1_i = 5'd12;
    #1;
    check_out("mid.head", 1'b1, 5'd11, 32'hB0);
    check("mid.hazard", 32'(hazard_o), 1);
    rst = 1'b1;
    #1;
    check("mid_rst.w_en",      32'(w_en_o), 0);
    check("mid_rst.hazard",    32'(hazard_o), 0);
    check("mid_rst.alu_ready", 32'(alu_ready_o), 0);
    check("mid_rst.lsu_ready", 32'(lsu_ready_o), 0);
    cyc();
    check("mid_rst.edge.w_en",   32'(w_en_o), 0);
    check("mid_rst.edge.hazard", 32'(hazard_o), 0);
    rst = 1'b0;
    #1;
    check("after_rst.w_en",      32'(w_en_o), 0);
    check("after_rst.hazard",    32'(hazard_o), 0);
    check("after_rst.alu_ready", 32'(alu_ready_o), 1);
    check("after_rst.lsu_ready", 32'(lsu_ready_o), 1);
    cyc();
    check("after_rst.c1.w_en", 32'(w_en_o), 0);
    $display("vec reset with 3 queued: done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
